// File: rtl/mmio_pkg.sv
// mmio_pkg: register map, STATUS bit positions and serialiser states for mmio_uart_tx
package mmio_pkg;
    localparam logic [31:0] TXDATA_OFF = 32'h0;
    localparam logic [31:0] STATUS_OFF = 32'h4;
    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo: power-of-two byte FIFO; push on full is accepted only alongside a pop
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (TXDATA/STATUS) feeding a byte FIFO and 8N1 serialiser
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frame).
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 50_000_000,
    parameter int          BAUD_RATE   = 115_200,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_write_data,
    input  logic        bus_write_en,
    input  logic        bus_read_en,
    output logic [31:0] bus_read_data,
    output logic        bus_read_valid,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW  = CPB > 1 ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    tx_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    data, dout;
    logic [AW:0]   count;
    logic [31:0]   status;
    logic full, empty, pop, push, ovf, bit_end, wr_tx, rd_st;
    logic unused_wdata;

    assign wr_tx        = bus_write_en && bus_addr == BASE_ADDR + TXDATA_OFF;
    assign rd_st        = bus_read_en && bus_addr == BASE_ADDR + STATUS_OFF;
    assign push         = wr_tx && (!full || pop);
    assign tx_busy      = state != IDLE || !empty;
    assign bit_end      = cnt == CW'(CPB - 1);
    assign unused_wdata = ^bus_write_data[31:8];

    sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   (bus_write_data[7:0]),
        .pop   (pop),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

`ifdef UART_TX_PARITY_EN
    localparam tx_state_t AFTER_DATA = PARITY;
    assign uart_tx = state == START ? 1'b0 : state == DATA ? data[idx] : state == PARITY ? ^data : 1'b1;
`else
    localparam tx_state_t AFTER_DATA = STOP;
    assign uart_tx = state == START ? 1'b0 : state == DATA ? data[idx] : 1'b1;
`endif

    always_comb begin
        status           = '0;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY]  = tx_busy;
        status[ST_OVF]   = ovf;
        status[ST_CNT +: 8] = 8'(count);
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_n;

    // STOP hands straight to START when more bytes wait, so frames abut
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                state_n = empty ? IDLE : START;
                pop     = !empty;
            end
            START: state_n = bit_end ? DATA : START;
            DATA:  state_n = bit_end && idx == 3'd7 ? AFTER_DATA : DATA;
`ifdef UART_TX_PARITY_EN
            PARITY: state_n = bit_end ? STOP : PARITY;
`endif
            STOP: begin
                state_n = !bit_end ? STOP : empty ? IDLE : START;
                pop     = bit_end && !empty;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt            <= '0;
            idx            <= '0;
            data           <= '0;
            ovf            <= 1'b0;
            bus_read_valid <= 1'b0;
            bus_read_data  <= '0;
        end else begin
            cnt            <= state == IDLE || bit_end ? '0 : cnt + 1'b1;
            idx            <= state != DATA ? '0 : bit_end ? idx + 1'b1 : idx;
            data           <= pop ? dout : data;
            ovf            <= (wr_tx && !push) || (ovf && !rd_st);
            bus_read_valid <= rd_st;
            bus_read_data  <= rd_st ? status : '0;
        end
endmodule
